// File: rtl/av_menu_overlay_if.sv
// Bus bundle between the video timing / button logic and the menu overlay.
// The overlay is the slave: it consumes raster position and buttons and
// returns the overlay pixel plus menu status.
interface av_menu_overlay_if #(
   parameter int NUM_ITEMS = 4
);
   localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

   logic [10:0]      hcount;
   logic [9:0]       vcount;
   logic             show;
   logic             btn_up;
   logic             btn_down;
   logic             btn_sel;
   logic [12:0]      menu_pixel;
   logic             menu_open;
   logic [SEL_W-1:0] sel_index;
   logic             sel_valid;

   modport master (
      output hcount, vcount, show, btn_up, btn_down, btn_sel,
      input  menu_pixel, menu_open, sel_index, sel_valid
   );

   modport slave (
      input  hcount, vcount, show, btn_up, btn_down, btn_sel,
      output menu_pixel, menu_open, sel_index, sel_valid
   );
endinterface

// File: rtl/av_menu_overlay.sv
// Menu overlay for the 1024x768 video path: rectangular panel with a
// vertical open/close wipe advanced once per frame, NUM_ITEMS rows with a
// cursor highlight, button navigation and a one-cycle select pulse.
// Output pixel is {opaque, RGB444}, registered one clock after hcount/vcount.
module av_menu_overlay #(
   parameter int          START_X    = 100,
   parameter int          START_Y    = 50,
   parameter int          WIDTH      = 800,
   parameter int          HEIGHT     = 600,
   parameter int          NUM_ITEMS  = 4,
   parameter int          ITEM_Y0    = 100,
   parameter int          ITEM_H     = 64,
   parameter int          ITEM_X0    = 40,
   parameter int          WIPE_STEP  = 40,
   parameter int          WRAP       = 1,
   parameter logic [11:0] BG_COLOR   = 12'hDDD,
   parameter logic [11:0] ITEM_COLOR = 12'hAAA,
   parameter logic [11:0] HL_COLOR   = 12'h36F
) (
   input  logic                clk65,
   input  logic                reset,
   av_menu_overlay_if.slave    bus
);

   localparam int SEL_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam int REV_W    = $clog2(HEIGHT + 1);
   localparam int ITEM_TOP = START_Y + ITEM_Y0;
   localparam int ITEM_BOT = ITEM_TOP + NUM_ITEMS * ITEM_H;
   localparam int ITEM_L   = START_X + ITEM_X0;
   localparam int ITEM_R   = START_X + WIDTH - ITEM_X0;

   typedef enum logic [1:0] {
      HIDDEN   = 2'd0,
      FADE_IN  = 2'd1,
      ACTIVE   = 2'd2,
      FADE_OUT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [REV_W-1:0]   rev_q, rev_d;
   logic [SEL_W-1:0]   cursor_q, cursor_d;
   logic               sel_valid_q, sel_valid_d;
   logic [12:0]        pixel_q, pixel_d;
   logic [31:0]        hl_top_q;
   logic               up_q, dn_q, sel_q;

   logic               frame_tick;
   logic               up_e, dn_e, sel_e;
   logic [31:0]        h_w, v_w;

   // Wipe grows by one step per frame, clamped at the full panel height.
   function automatic logic [REV_W-1:0] wipe_up(input logic [REV_W-1:0] r);
      int s;
      s = int'(r) + WIPE_STEP;
      return (s >= HEIGHT) ? REV_W'(HEIGHT) : REV_W'(s);
   endfunction

   // Wipe shrinks by one step per frame, clamped at zero.
   function automatic logic [REV_W-1:0] wipe_down(input logic [REV_W-1:0] r);
      return (int'(r) <= WIPE_STEP) ? '0 : (r - REV_W'(WIPE_STEP));
   endfunction

   function automatic logic [SEL_W-1:0] cursor_inc(input logic [SEL_W-1:0] c);
      if (c == SEL_W'(NUM_ITEMS - 1)) return (WRAP != 0) ? '0 : c;
      return c + SEL_W'(1);
   endfunction

   function automatic logic [SEL_W-1:0] cursor_dec(input logic [SEL_W-1:0] c);
      if (c == '0) return (WRAP != 0) ? SEL_W'(NUM_ITEMS - 1) : c;
      return c - SEL_W'(1);
   endfunction

   assign frame_tick = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
   assign up_e       = bus.btn_up   & ~up_q;
   assign dn_e       = bus.btn_down & ~dn_q;
   assign sel_e      = bus.btn_sel  & ~sel_q;
   assign h_w        = 32'(bus.hcount);
   assign v_w        = 32'(bus.vcount);

   // Next-state: wipe sequencing, cursor navigation and select detection.
   always_comb begin
      state_d     = state_q;
      rev_d       = rev_q;
      cursor_d    = cursor_q;
      sel_valid_d = 1'b0;
      case (state_q)
         HIDDEN: begin
            if (bus.show) state_d = FADE_IN;
         end
         FADE_IN: begin
            if (!bus.show) begin
               state_d = FADE_OUT;
            end else if (frame_tick) begin
               rev_d = wipe_up(rev_q);
               if (wipe_up(rev_q) == REV_W'(HEIGHT)) state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!bus.show) state_d = FADE_OUT;
            // A select in the same cycle as a navigation edge wins.
            if (sel_e) begin
               sel_valid_d = 1'b1;
            end else if (up_e && !dn_e) begin
               cursor_d = cursor_dec(cursor_q);
            end else if (dn_e && !up_e) begin
               cursor_d = cursor_inc(cursor_q);
            end
         end
         FADE_OUT: begin
            if (bus.show) begin
               state_d = FADE_IN;
            end else if (frame_tick) begin
               rev_d = wipe_down(rev_q);
               if (wipe_down(rev_q) == '0) state_d = HIDDEN;
            end
         end
         default: state_d = HIDDEN;
      endcase
   end

   // Pixel classification for the current raster position.
   always_comb begin
      pixel_d = '0;
      if (h_w >= START_X && h_w < START_X + WIDTH &&
          v_w >= START_Y && v_w < START_Y + 32'(rev_q)) begin
         pixel_d = {1'b1, BG_COLOR};
         if (h_w >= ITEM_L && h_w < ITEM_R && v_w >= ITEM_TOP && v_w < ITEM_BOT) begin
            if (v_w >= hl_top_q && v_w < hl_top_q + ITEM_H)
               pixel_d = {1'b1, HL_COLOR};
            else
               pixel_d = {1'b1, ITEM_COLOR};
         end
      end
   end

   // State, cursor, pixel and button history registers.
   always_ff @(posedge clk65) begin
      if (reset) begin
         state_q     <= HIDDEN;
         rev_q       <= '0;
         cursor_q    <= '0;
         sel_valid_q <= 1'b0;
         pixel_q     <= '0;
         hl_top_q    <= 32'(ITEM_TOP);
         // Track the live levels so a button held through reset is not an edge.
         up_q        <= bus.btn_up;
         dn_q        <= bus.btn_down;
         sel_q       <= bus.btn_sel;
      end else begin
         state_q     <= state_d;
         rev_q       <= rev_d;
         cursor_q    <= cursor_d;
         sel_valid_q <= sel_valid_d;
         pixel_q     <= pixel_d;
         // Highlight top follows the cursor one clock later.
         hl_top_q    <= 32'(ITEM_TOP) + 32'(cursor_q) * 32'(ITEM_H);
         up_q        <= bus.btn_up;
         dn_q        <= bus.btn_down;
         sel_q       <= bus.btn_sel;
      end
   end

   assign bus.menu_pixel = pixel_q;
   assign bus.menu_open  = (state_q == ACTIVE);
   assign bus.sel_index  = cursor_q;
   assign bus.sel_valid  = sel_valid_q;

endmodule

// File: tb/tb_av_menu_overlay.sv
// Bench for av_menu_overlay: a wrapping and a saturating instance share one
// stimulus stream; a per-cycle reference model checks every output, and
// directed sequences plus a vector table check the documented corner cases.
module tb_av_menu_overlay;

   localparam int NI = 4;

   logic clk65 = 1'b0;
   always #5 clk65 = ~clk65;

   logic        reset;
   logic [10:0] h;
   logic [9:0]  v;
   logic        show, up, dn, sel;

   av_menu_overlay_if #(.NUM_ITEMS(NI)) bw ();
   av_menu_overlay_if #(.NUM_ITEMS(NI)) bn ();

   assign bw.hcount = h;   assign bn.hcount = h;
   assign bw.vcount = v;   assign bn.vcount = v;
   assign bw.show = show;  assign bn.show = show;
   assign bw.btn_up = up;  assign bn.btn_up = up;
   assign bw.btn_down = dn; assign bn.btn_down = dn;
   assign bw.btn_sel = sel; assign bn.btn_sel = sel;

   av_menu_overlay #(.WRAP(1)) dut_w (.clk65(clk65), .reset(reset), .bus(bw.slave));
   av_menu_overlay #(.WRAP(0)) dut_n (.clk65(clk65), .reset(reset), .bus(bn.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: revealed height, opening direction, open flag,
   // cursor per instance (0 = wrapping, 1 = saturating) and the cursor
   // value the highlight currently shows.
   int          m_rev = 0;
   bit          m_dir = 0;
   bit          m_act = 0;
   int          m_cur [2] = '{0, 0};
   int          m_hl  [2] = '{0, 0};
   bit          m_pu = 0, m_pd = 0, m_ps = 0;
   logic [12:0] e_pix [2] = '{13'h0, 13'h0};
   bit          e_sv = 0;

   function automatic logic [12:0] ref_pixel(input int x, input int y, input int rev, input int cur);
      int row;
      if (!(x >= 100 && x < 900 && y >= 50 && y < 50 + rev)) return 13'h0;
      if (x >= 140 && x < 860 && y >= 150 && y < 150 + NI * 64) begin
         row = (y - 150) / 64;
         return (row == cur) ? 13'h136F : 13'h1AAA;
      end
      return 13'h1DDD;
   endfunction

   task automatic model_step();
      bit upe, dne, sle, tick;
      if (reset) begin
         m_rev = 0; m_dir = 0; m_act = 0;
         m_cur = '{0, 0}; m_hl = '{0, 0};
         e_pix = '{13'h0, 13'h0}; e_sv = 0;
      end else begin
         upe  = up  && !m_pu;
         dne  = dn  && !m_pd;
         sle  = sel && !m_ps;
         tick = (h == 0) && (v == 0);
         for (int k = 0; k < 2; k++) e_pix[k] = ref_pixel(int'(h), int'(v), m_rev, m_hl[k]);
         e_sv = m_act && sle;
         for (int k = 0; k < 2; k++) m_hl[k] = m_cur[k];
         if (m_act && !sle && (upe != dne)) begin
            for (int k = 0; k < 2; k++) begin
               if (dne) m_cur[k] = (m_cur[k] == NI - 1) ? ((k == 0) ? 0 : m_cur[k]) : m_cur[k] + 1;
               else     m_cur[k] = (m_cur[k] == 0) ? ((k == 0) ? NI - 1 : 0) : m_cur[k] - 1;
            end
         end
         if (show != m_dir) begin
            m_dir = show;
            m_act = 0;
         end else if (tick) begin
            if (m_dir) begin
               m_rev = (m_rev + 40 > 600) ? 600 : m_rev + 40;
               if (m_rev == 600) m_act = 1;
            end else begin
               m_rev = (m_rev < 40) ? 0 : m_rev - 40;
            end
         end
      end
      m_pu = up; m_pd = dn; m_ps = sel;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("model_pix_wrap",   32'(bw.menu_pixel), 32'(e_pix[0]));
      chk("model_pix_sat",    32'(bn.menu_pixel), 32'(e_pix[1]));
      chk("model_open_wrap",  32'(bw.menu_open),  32'(m_act));
      chk("model_open_sat",   32'(bn.menu_open),  32'(m_act));
      chk("model_idx_wrap",   32'(bw.sel_index),  32'(m_cur[0]));
      chk("model_idx_sat",    32'(bn.sel_index),  32'(m_cur[1]));
      chk("model_selv_wrap",  32'(bw.sel_valid),  32'(e_sv));
      chk("model_selv_sat",   32'(bn.sel_valid),  32'(e_sv));
   endtask

   // One clock: drive raster position, let the edge happen, update model, compare.
   task automatic cycle(input logic [10:0] hh, input logic [9:0] vv);
      h = hh; v = vv;
      @(posedge clk65);
      model_step();
      #1;
      check_model();
   endtask

   task automatic idle();
      cycle(11'd1500, 10'd900);
   endtask

   task automatic tick_frame();
      cycle(11'd0, 10'd0);
      idle();
   endtask

   // Reveal height r is visible as the last opaque line of the panel.
   task automatic probe_rev(input int r);
      if (r > 0) begin
         cycle(11'd100, 10'(50 + r - 1));
         chk("rev_inside", 32'(bn.menu_pixel), 32'h1DDD);
      end
      if (r < 600) begin
         cycle(11'd100, 10'(50 + r));
         chk("rev_below", 32'(bn.menu_pixel), 32'h0);
      end
   endtask

   typedef struct {
      int          x;
      int          y;
      logic [12:0] exp;
   } pix_vec_t;

   pix_vec_t vecs [16];
   int pulses, idx;

   initial begin
      // Pixel expectations with the panel fully open and cursor on row 2.
      vecs[0]  = '{140, 278, 13'h136F};
      vecs[1]  = '{139, 278, 13'h1DDD};
      vecs[2]  = '{900,  50, 13'h0000};
      vecs[3]  = '{899,  50, 13'h1DDD};
      vecs[4]  = '{100,  50, 13'h1DDD};
      vecs[5]  = '{ 99,  50, 13'h0000};
      vecs[6]  = '{100, 649, 13'h1DDD};
      vecs[7]  = '{100, 650, 13'h0000};
      vecs[8]  = '{140, 150, 13'h1AAA};
      vecs[9]  = '{859, 341, 13'h136F};
      vecs[10] = '{860, 278, 13'h1DDD};
      vecs[11] = '{140, 342, 13'h1AAA};
      vecs[12] = '{140, 405, 13'h1AAA};
      vecs[13] = '{140, 406, 13'h1DDD};
      vecs[14] = '{140, 277, 13'h1AAA};
      vecs[15] = '{500,  49, 13'h0000};

      // Reset with select held.
      reset = 1'b1; show = 1'b0; up = 1'b0; dn = 1'b0; sel = 1'b1;
      h = 11'd1500; v = 10'd900;
      idle(); idle();
      chk("reset_pixel", 32'(bw.menu_pixel), 32'h0);
      chk("reset_open",  32'(bw.menu_open),  32'h0);
      chk("reset_selv",  32'(bw.sel_valid),  32'h0);
      chk("reset_idx",   32'(bw.sel_index),  32'h0);
      reset = 1'b0; sel = 1'b0;
      idle();

      // Open: 15 frame ticks reveal 40 lines each.
      show = 1'b1;
      idle();
      probe_rev(0);
      for (int k = 1; k <= 15; k++) begin
         tick_frame();
         chk("open_after_tick", 32'(bw.menu_open), 32'(k == 15));
         probe_rev(40 * k);
      end

      // Navigation: down x3, then down at the last row.
      for (int k = 0; k < 3; k++) begin
         dn = 1'b1; idle(); dn = 1'b0; idle();
      end
      chk("nav_down3_wrap", 32'(bw.sel_index), 32'd3);
      chk("nav_down3_sat",  32'(bn.sel_index), 32'd3);
      dn = 1'b1; idle(); dn = 1'b0; idle();
      chk("nav_wrap_last", 32'(bw.sel_index), 32'd0);
      chk("nav_sat_last",  32'(bn.sel_index), 32'd3);
      up = 1'b1; dn = 1'b1; idle(); up = 1'b0; dn = 1'b0; idle();
      chk("nav_both_wrap", 32'(bw.sel_index), 32'd0);
      chk("nav_both_sat",  32'(bn.sel_index), 32'd3);
      up = 1'b1; idle(); up = 1'b0; idle();
      chk("nav_wrap_first", 32'(bw.sel_index), 32'd3);
      chk("nav_up_sat",     32'(bn.sel_index), 32'd2);

      // Held select gives exactly one pulse carrying the cursor.
      sel = 1'b1; pulses = 0; idx = -1;
      for (int i = 0; i < 6; i++) begin
         idle();
         if (bn.sel_valid) begin pulses++; idx = int'(bn.sel_index); end
      end
      sel = 1'b0; idle();
      chk("sel_pulses", 32'(pulses), 32'd1);
      chk("sel_index",  32'(idx),    32'd2);

      // Navigation edge coinciding with select is ignored.
      sel = 1'b1; dn = 1'b1; idle(); sel = 1'b0; dn = 1'b0; idle();
      chk("sel_blocks_nav", 32'(bn.sel_index), 32'd2);

      // Pixel table.
      for (int i = 0; i < 16; i++) begin
         cycle(11'(vecs[i].x), 10'(vecs[i].y));
         chk("pix_table", 32'(bn.menu_pixel), 32'(vecs[i].exp));
      end

      // Close fully, reopen to 200, reverse at 200, reopen at 80.
      show = 1'b0; idle();
      chk("close_open_flag", 32'(bw.menu_open), 32'h0);
      for (int k = 1; k <= 15; k++) begin
         tick_frame();
         probe_rev(600 - 40 * k);
      end
      show = 1'b1; idle();
      for (int k = 1; k <= 5; k++) tick_frame();
      probe_rev(200);
      show = 1'b0; idle();
      for (int k = 1; k <= 3; k++) begin
         tick_frame();
         probe_rev(200 - 40 * k);
      end
      show = 1'b1; idle();
      tick_frame();
      probe_rev(120);
      for (int k = 1; k <= 12; k++) begin
         tick_frame();
         chk("reopen_open_flag", 32'(bw.menu_open), 32'(k == 12));
      end

      // Reset during closing wipe with select held.
      show = 1'b0; idle();
      for (int k = 0; k < 3; k++) tick_frame();
      sel = 1'b1; idle();
      reset = 1'b1; idle();
      chk("rst_mid_pixel", 32'(bw.menu_pixel), 32'h0);
      chk("rst_mid_open",  32'(bw.menu_open),  32'h0);
      chk("rst_mid_idx_w", 32'(bw.sel_index),  32'h0);
      chk("rst_mid_idx_n", 32'(bn.sel_index),  32'h0);
      chk("rst_mid_selv",  32'(bw.sel_valid),  32'h0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle(11'd100, 10'd50);
         chk("post_rst_selv", 32'(bw.sel_valid), 32'h0);
      end
      chk("post_rst_pixel", 32'(bw.menu_pixel), 32'h0);
      sel = 1'b0;

      // Random stimulus against the model.
      show = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(499, 0) == 0) show = ~show;
         reset = ($urandom_range(999, 0) == 0);
         up  = ($urandom_range(7, 0) == 0);
         dn  = ($urandom_range(7, 0) == 0);
         sel = ($urandom_range(9, 0) == 0);
         if ($urandom_range(24, 0) == 0) cycle(11'd0, 10'd0);
         else cycle(11'($urandom_range(1023, 0)), 10'($urandom_range(767, 0)));
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
